// File: rtl/mau_pkg.sv
// mau_pkg: shared types and helpers for the MEM-stage load/store unit
package mau_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_e;
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, STORE, ERR, RESP} state_e;
  function automatic logic is_misaligned(input logic [1:0] addr, input size_e size);
    return size == SZ_RSVD || (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr != 2'b00);
  endfunction
endpackage

// File: rtl/mau_lane_align.sv
// mau_lane_align: byte-lane extraction (load) and merge (sub-word store); ports rdata/offset/size/sgn -> ext, old/wdata -> merged
module mau_lane_align
  import mau_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        offset,
  input  size_e             size,
  input  logic              sgn,
  input  logic [DATA_W-1:0] old,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ext,
  output logic [DATA_W-1:0] merged
);
  logic [DATA_W-1:0] sh, mask;
  logic [4:0] bits;
  always_comb begin
    bits = size == SZ_HALF ? {offset[1], 4'b0} : {offset, 3'b0};
    sh = rdata >> bits;
    ext = size == SZ_BYTE ? {{(DATA_W-8){sgn & sh[7]}}, sh[7:0]} :
          size == SZ_HALF ? {{(DATA_W-16){sgn & sh[15]}}, sh[15:0]} : rdata;
    mask = (size == SZ_BYTE ? DATA_W'(8'hFF) : DATA_W'(16'hFFFF)) << bits;
    merged = (old & ~mask) | ((wdata << bits) & mask);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store controller; req_* in, rsp_* out, mem_* to word-wide memory; MAU_MISALIGN_CHECK_EN enables the error path
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_e state, nxt, start;
  size_e size, in_size, lat_size;
  logic [ADDR_W-1:0] addr, lat_addr;
  logic [DATA_W-1:0] wdata, merge_q, ext, merged;
  logic sgn, acc, bad;
  assign in_size = size_e'(req_size);
  assign acc = req_valid && req_ready;
`ifdef MAU_MISALIGN_CHECK_EN
  logic err_q;
  assign bad = is_misaligned(req_addr[1:0], in_size);
  assign lat_size = in_size;
  assign lat_addr = req_addr;
  assign rsp_err = err_q;
`else
  // Without checking, reserved size acts as word and the address snaps down to natural alignment
  assign bad = 1'b0;
  assign lat_size = in_size == SZ_RSVD ? SZ_WORD : in_size;
  assign lat_addr = {req_addr[ADDR_W-1:2],
                     lat_size == SZ_WORD ? 1'b0 : req_addr[1],
                     lat_size == SZ_BYTE ? req_addr[0] : 1'b0};
  assign rsp_err = 1'b0;
`endif
  assign start = bad ? ERR : !req_write ? LOAD : lat_size == SZ_WORD ? STORE : RMW_RD;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE   ? (acc ? start : IDLE) :
          state == RMW_RD ? STORE :
          state == RESP   ? (rsp_ready ? IDLE : RESP) : RESP;
  always_comb begin
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
    mem_read = state == LOAD || state == RMW_RD;
    mem_write = state == STORE;
    mem_addr = mem_read || mem_write ? {addr[ADDR_W-1:2], 2'b00} : '0;
    mem_wdata = mem_write ? (size == SZ_WORD ? wdata : merged) : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      addr <= '0;
      size <= SZ_BYTE;
      sgn <= 1'b0;
      wdata <= '0;
      merge_q <= '0;
      rsp_rdata <= '0;
    end else begin
      if (acc) begin
        addr <= lat_addr;
        size <= lat_size;
        sgn <= req_signed;
        wdata <= req_wdata;
        rsp_rdata <= '0;
      end
      if (state == LOAD) rsp_rdata <= ext;
      if (state == RMW_RD) merge_q <= mem_rdata;
    end
`ifdef MAU_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) err_q <= 1'b0;
    else if (acc) err_q <= 1'b0;
    else if (state == ERR) err_q <= 1'b1;
`endif
  mau_lane_align #(.DATA_W(DATA_W)) u_align (
    .rdata(mem_rdata), .offset(addr[1:0]), .size(size), .sgn(sgn),
    .old(merge_q), .wdata(wdata), .ext(ext), .merged(merged)
  );
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized bench for mem_access_unit against a byte-array reference model
module tb_mem_access_unit;
  logic clk = 0, reset = 1;
  logic req_valid = 0, req_write = 0, req_signed = 0, rsp_ready = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, rsp_valid, rsp_err, mem_write, mem_read;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:255];
  logic [31:0] init_w [0:255];
  logic load_mem = 1;
  logic [7:0] ref_b [0:1023];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mem_access_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk)
    if (load_mem) for (int i = 0; i < 256; i++) mem[i] <= init_w[i];
    else if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_word(input int wi);
    return {ref_b[4*wi+3], ref_b[4*wi+2], ref_b[4*wi+1], ref_b[4*wi]};
  endfunction
  task automatic do_req(input bit w, input bit [1:0] sz, input bit sg, input bit [9:0] a,
                        input bit [31:0] wd, input int stall, output logic [31:0] rd, output logic er);
    bit err;
    int es, n, ea, lat, nr, nw, exp_lat;
    bit [31:0] v;
`ifdef MAU_MISALIGN_CHECK_EN
    err = sz == 3 || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0);
    es = sz;
`else
    err = 0;
    es = sz == 3 ? 2 : sz;
`endif
    n = 1 << es;
    ea = err ? int'(a) : int'(a) - int'(a) % n;
    v = 0;
    if (!err && !w) begin
      for (int i = 0; i < n; i++) v |= 32'(ref_b[ea+i]) << (8*i);
      if (sg && n < 4 && v[8*n-1]) v |= 32'hFFFFFFFF << (8*n);
    end
    exp_lat = err ? 2 : (w && n < 4) ? 3 : 2;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = {22'h0, a}; req_wdata = wd; rsp_ready = 0;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 1; nr = 0; nw = 0;
    while (!rsp_valid && lat < 10) begin
      nr += int'(mem_read); nw += int'(mem_write);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("mem_read_pulses", nr, (!err && (!w || n < 4)) ? 1 : 0);
    chk("mem_write_pulses", nw, (!err && w) ? 1 : 0);
    chk("rsp_rdata", rsp_rdata, v);
    chk("rsp_err", rsp_err, err);
    rd = rsp_rdata; er = rsp_err;
    if (!err && w) for (int i = 0; i < n; i++) ref_b[ea+i] = 8'((wd >> (8*i)) & 32'hFF);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_valid", rsp_valid, 1);
      chk("stall_rdata", rsp_rdata, rd);
      chk("stall_ready", req_ready, 0);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("released_ready", req_ready, 1);
    chk("released_valid", rsp_valid, 0);
    chk("mem_word", mem[a[9:2]], ref_word(int'(a[9:2])));
  endtask
  initial begin
    logic [31:0] rd;
    logic er;
    for (int i = 0; i < 256; i++) begin
      init_w[i] = $urandom;
      for (int b = 0; b < 4; b++) ref_b[4*i+b] = 8'(init_w[i] >> (8*b));
    end
    @(posedge clk); @(posedge clk); #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_mem_ctl", {mem_read, mem_write}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    load_mem = 0; reset = 0;
    @(posedge clk); #1;
    do_req(1, 2, 0, 10'h100, 32'hDEADBEEF, 0, rd, er);
    do_req(0, 2, 0, 10'h100, 0, 0, rd, er);
    chk("t1_lw", rd, 32'hDEADBEEF);
    do_req(1, 2, 0, 10'h100, 32'h11223344, 0, rd, er);
    do_req(1, 0, 0, 10'h101, 32'h000000AA, 0, rd, er);
    chk("t2_word", mem[8'h40], 32'h1122AA44);
    do_req(0, 0, 1, 10'h101, 0, 0, rd, er);
    chk("t3_lb", rd, 32'hFFFFFFAA);
    do_req(0, 0, 0, 10'h101, 0, 0, rd, er);
    chk("t3_lbu", rd, 32'h000000AA);
    do_req(0, 1, 1, 10'h102, 0, 0, rd, er);
    chk("t3_lh", rd, 32'h00001122);
    do_req(0, 2, 0, 10'h102, 0, 0, rd, er);
`ifdef MAU_MISALIGN_CHECK_EN
    chk("t4_err", er, 1);
`else
    chk("t4_lw_fold", rd, 32'h1122AA44);
`endif
    do_req(0, 2, 0, 10'h100, 0, 5, rd, er);
    chk("t5_lw", rd, 32'h1122AA44);
    req_valid = 1; req_write = 1; req_size = 2; req_signed = 0;
    req_addr = 32'h200; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 0;
    chk("t6_store_active", mem_write, 1);
    reset = 1; #1;
    chk("t6_write_drop", mem_write, 0);
    chk("t6_read", mem_read, 0);
    chk("t6_req_ready", req_ready, 1);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_mem_addr", mem_addr, 0);
    chk("t6_mem_wdata", mem_wdata, 0);
    chk("t6_rsp_rdata", rsp_rdata, 0);
    #2 reset = 0;
    @(posedge clk); #1;
    chk("t6_mem_unchanged", mem[8'h80], ref_word(8'h80));
    for (int k = 0; k < 300; k++)
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             10'($urandom_range(0, 1023)), $urandom, int'($urandom_range(0, 3)), rd, er);
    for (int i = 0; i < 256; i++) chk("final_mem", mem[i], ref_word(i));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
